// File: rtl/noc_proc_iface.sv
// noc_proc_iface: processor-side network interface for one node of the 2x2 mesh.
// The TX path queues send requests and presents them to the router through a
// three-state send sequencer. The RX path queues flits the router delivers.
// Optional build macro: NOC_IFACE_LOOPBACK_EN (self-addressed flits bypass the
// router and go straight into the local RX queue).
//
// State  | Meaning
// -------+-------------------------------------------------------------
// IDLE   | configure[0]=0; waiting for a TX head (and no global block)
// DRIVE  | configure holds the flit with strobe set until router_ready
// GAP    | one cycle with strobe low, dest/payload held, then IDLE
module noc_proc_iface #(
  parameter int NODE_ID   = 0,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [1:0]  tx_dest,
  input  logic [7:0]  tx_data,
  output logic [10:0] configure,
  input  logic        router_ready,
  input  logic        block_all_paths,
  input  logic [8:0]  recieve_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic [7:0]  tx_sent_count,
  output logic [7:0]  rx_drop_count
);

  localparam int TAW = $clog2(TXQ_DEPTH);
  localparam int RAW = $clog2(RXQ_DEPTH);
  localparam logic [TAW:0] TPTR_ONE = 1;
  localparam logic [RAW:0] RPTR_ONE = 1;

  // Elaboration guard: the mesh only has four nodes.
  if (NODE_ID < 0 || NODE_ID > 3) begin : g_bad_node_id
    $error("noc_proc_iface: NODE_ID must be in 0..3");
  end

`ifdef NOC_IFACE_LOOPBACK_EN
  localparam logic [1:0] NODE_ADDR = NODE_ID[1:0];
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [10:0]  cfg_q, cfg_d;
  logic [7:0]   sent_q, sent_d;
  logic [7:0]   drop_q, drop_d;
  logic         live_q;

  // TX queue storage and pointers (extra MSB distinguishes full from empty)
  logic [1:0]   txq_dest_q [TXQ_DEPTH];
  logic [7:0]   txq_data_q [TXQ_DEPTH];
  logic [TAW:0] tx_wr_q, tx_wr_d;
  logic [TAW:0] tx_rd_q, tx_rd_d;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [1:0]   head_dest;
  logic [7:0]   head_data;

  // RX queue storage and pointers
  logic [7:0]   rxq_data_q [RXQ_DEPTH];
  logic [RAW:0] rx_wr_q, rx_wr_d;
  logic [RAW:0] rx_rd_q, rx_rd_d;
  logic         rx_empty, rx_full, rx_pop, rx_push;
  logic         rtr_flit, rtr_accept, rtr_drop, lb_push;
  logic [7:0]   rx_push_data;

  assign tx_empty  = (tx_wr_q == tx_rd_q);
  assign tx_full   = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                     (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  // live_q keeps tx_ready low until the first edge after reset release.
  assign tx_ready  = live_q && !tx_full;
  assign tx_push   = tx_valid && tx_ready;
  assign head_dest = txq_dest_q[tx_rd_q[TAW-1:0]];
  assign head_data = txq_data_q[tx_rd_q[TAW-1:0]];

  assign rx_empty  = (rx_wr_q == rx_rd_q);
  assign rx_full   = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                     (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
  assign rx_valid  = !rx_empty;
  assign rx_data   = rx_empty ? 8'h00 : rxq_data_q[rx_rd_q[RAW-1:0]];
  assign rx_pop    = rx_valid && rx_ready;

  // A full queue still takes a router flit when the head leaves that same cycle.
  assign rtr_flit     = recieve_data[8];
  assign rtr_accept   = rtr_flit && (!rx_full || rx_pop);
  assign rtr_drop     = rtr_flit && rx_full && !rx_pop;
  assign rx_push      = rtr_accept || lb_push;
  assign rx_push_data = rtr_flit ? recieve_data[7:0] : head_data;

  assign configure     = cfg_q;
  assign tx_sent_count = sent_q;
  assign rx_drop_count = drop_q;

  // Send sequencer next-state and configure word
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    tx_pop  = 1'b0;
    lb_push = 1'b0;
    sent_d  = sent_q;
    unique case (state_q)
      ST_IDLE: begin
        cfg_d[0] = 1'b0;
`ifdef NOC_IFACE_LOOPBACK_EN
        // Local flits wait for a free RX slot and for the router push to clear.
        if (!tx_empty && (head_dest == NODE_ADDR)) begin
          if (!rtr_flit && !rx_full) begin
            tx_pop  = 1'b1;
            lb_push = 1'b1;
          end
        end else
`endif
        if (!tx_empty && !block_all_paths) begin
          cfg_d   = {head_data, head_dest, 1'b1};
          tx_pop  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (router_ready) begin
          cfg_d[0] = 1'b0;
          sent_d   = sent_q + 8'd1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        cfg_d[0] = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        cfg_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer and drop-counter next-state
  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    drop_d  = drop_q;
    if (tx_push) tx_wr_d = tx_wr_q + TPTR_ONE;
    if (tx_pop)  tx_rd_d = tx_rd_q + TPTR_ONE;
    if (rx_push) rx_wr_d = rx_wr_q + RPTR_ONE;
    if (rx_pop)  rx_rd_d = rx_rd_q + RPTR_ONE;
    if (rtr_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Control state: sequencer, counters, queue pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
      live_q  <= 1'b0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
      live_q  <= 1'b1;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  // Queue storage; contents are only visible through valid pointers
  always_ff @(posedge clock) begin
    if (tx_push) begin
      txq_dest_q[tx_wr_q[TAW-1:0]] <= tx_dest;
      txq_data_q[tx_wr_q[TAW-1:0]] <= tx_data;
    end
    if (rx_push) begin
      rxq_data_q[rx_wr_q[RAW-1:0]] <= rx_push_data;
    end
  end

endmodule

// File: tb/tb_noc_proc_iface.sv
// Directed bench for noc_proc_iface. Build with NOC_IFACE_LOOPBACK_EN defined
// to include the loopback scenario (instance uses NODE_ID=2 in that build).
module tb_noc_proc_iface;

`ifdef NOC_IFACE_LOOPBACK_EN
  localparam int TB_NODE = 2;
`else
  localparam int TB_NODE = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [1:0]  tx_dest = 2'd0;
  logic [7:0]  tx_data = 8'd0;
  logic [10:0] configure;
  logic        router_ready = 1'b0;
  logic        block_all_paths = 1'b0;
  logic [8:0]  recieve_data = 9'd0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic [7:0]  tx_sent_count;
  logic [7:0]  rx_drop_count;

  int n_cmp = 0;
  int n_err = 0;

  noc_proc_iface #(.NODE_ID(TB_NODE), .TXQ_DEPTH(4), .RXQ_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
    .configure(configure), .router_ready(router_ready), .block_all_paths(block_all_paths),
    .recieve_data(recieve_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_sent_count(tx_sent_count), .rx_drop_count(rx_drop_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (configure !== 11'd0) begin n_err++; $display("FAIL reset_cfg: got %h want 000", configure); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx: got v=%b d=%h want 0/00", rx_valid, rx_data); end
    n_cmp++; if (tx_sent_count !== 8'd0 || rx_drop_count !== 8'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", tx_sent_count, rx_drop_count); end
    reset = 1'b1;
    tick();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_single_send();
    router_ready = 1'b1;
    tx_valid = 1'b1; tx_dest = 2'd1; tx_data = 8'h01;
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (configure[0] !== 1'b0) begin n_err++; $display("FAIL single_pre: got %b want 0", configure[0]); end
    tick();
    n_cmp++; if (configure !== 11'b00000001011) begin n_err++; $display("FAIL single_drive: got %b want 00000001011", configure); end
    tick();
    n_cmp++; if (configure !== 11'b00000001010) begin n_err++; $display("FAIL single_gap: got %b want 00000001010", configure); end
    n_cmp++; if (tx_sent_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", tx_sent_count); end
    tick();
    n_cmp++; if (configure[0] !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", configure[0]); end
  endtask

  task automatic test_router_stall();
    int bad = 0;
    router_ready = 1'b0;
    tx_valid = 1'b1; tx_dest = 2'd1; tx_data = 8'h01;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (configure !== 11'b00000001011) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: %0d of 10 cycles wrong, last %b want 00000001011", bad, configure); end
    router_ready = 1'b1;
    tick();
    n_cmp++; if (configure !== 11'b00000001010) begin n_err++; $display("FAIL stall_gap: got %b want 00000001010", configure); end
    n_cmp++; if (tx_sent_count !== 8'd2) begin n_err++; $display("FAIL stall_count: got %0d want 2", tx_sent_count); end
    tick();
  endtask

  task automatic test_tx_full();
    do_reset();
    block_all_paths = 1'b1; router_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_dest = 2'd3; tx_data = 8'h20 + 8'(i);
      tick();
    end
    tx_valid = 1'b0;
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL full_tx_ready: got %b want 0", tx_ready); end
    n_cmp++; if (configure !== 11'd0) begin n_err++; $display("FAIL full_cfg_blocked: got %h want 000", configure); end
    block_all_paths = 1'b0; router_ready = 1'b1;
    tick();
    n_cmp++; if (configure !== 11'h107) begin n_err++; $display("FAIL full_first_drive: got %h want 107", configure); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got %b want 1", tx_ready); end
    for (int i = 0; i < 11; i++) tick();
    n_cmp++; if (tx_sent_count !== 8'd4 || configure !== 11'h11E) begin n_err++; $display("FAIL full_drain: got cnt=%0d cfg=%h want 4/11e", tx_sent_count, configure); end
    tick(); tick(); tick();
    n_cmp++; if (tx_sent_count !== 8'd4 || configure !== 11'h11E) begin n_err++; $display("FAIL full_fifth_rejected: got cnt=%0d cfg=%h want 4/11e", tx_sent_count, configure); end
  endtask

  task automatic test_rx_overflow();
    rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      recieve_data = {1'b1, 8'h10 + 8'(i)};
      tick();
    end
    recieve_data = 9'd0;
    n_cmp++; if (rx_drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drops: got %0d want 2", rx_drop_count); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", rx_valid); end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_data !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL ovf_pop%0d: got %h want %h", i, rx_data, 8'h10 + 8'(i)); end
      tick();
    end
    rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_rx_full_pop();
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      recieve_data = {1'b1, 8'h30 + 8'(i)};
      tick();
    end
    recieve_data = {1'b1, 8'h34}; rx_ready = 1'b1;
    tick();
    recieve_data = 9'd0; rx_ready = 1'b0;
    n_cmp++; if (rx_drop_count !== 8'd2 || rx_data !== 8'h31) begin n_err++; $display("FAIL fullpop: got drops=%0d head=%h want 2/31", rx_drop_count, rx_data); end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_data !== 8'h31 + 8'(i)) begin n_err++; $display("FAIL fullpop_pop%0d: got %h want %h", i, rx_data, 8'h31 + 8'(i)); end
      tick();
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    router_ready = 1'b0;
    tx_valid = 1'b1; tx_dest = 2'd1; tx_data = 8'h77;
    tick();
    tx_valid = 1'b0;
    recieve_data = {1'b1, 8'h44};
    tick();
    recieve_data = 9'd0;
    n_cmp++; if (configure[0] !== 1'b1 || rx_valid !== 1'b1) begin n_err++; $display("FAIL middrive_pre: got strobe=%b rxv=%b want 1/1", configure[0], rx_valid); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (configure !== 11'd0) begin n_err++; $display("FAIL middrive_cfg: got %h want 000", configure); end
    n_cmp++; if (tx_sent_count !== 8'd0 || rx_drop_count !== 8'd0) begin n_err++; $display("FAIL middrive_counts: got %0d/%0d want 0/0", tx_sent_count, rx_drop_count); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || tx_ready !== 1'b0) begin n_err++; $display("FAIL middrive_flags: got rxv=%b rxd=%h txr=%b want 0/00/0", rx_valid, rx_data, tx_ready); end
    tick();
    reset = 1'b1; router_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (configure !== 11'd0 || tx_sent_count !== 8'd0) begin n_err++; $display("FAIL middrive_lost: got cfg=%h cnt=%0d want 000/0", configure, tx_sent_count); end
  endtask

  task automatic test_back_to_back();
    router_ready = 1'b1;
    tx_valid = 1'b1; tx_dest = 2'd1; tx_data = 8'h5A;
    tick();
    tx_dest = 2'd3; tx_data = 8'h5B;
    tick();
    tx_valid = 1'b0;
    n_cmp++; if (configure !== 11'h2D3) begin n_err++; $display("FAIL b2b_drive0: got %h want 2d3", configure); end
    tick();
    n_cmp++; if (configure !== 11'h2D2) begin n_err++; $display("FAIL b2b_gap0: got %h want 2d2", configure); end
    tick();
    n_cmp++; if (configure !== 11'h2D2) begin n_err++; $display("FAIL b2b_idle: got %h want 2d2", configure); end
    tick();
    n_cmp++; if (configure !== 11'h2DF) begin n_err++; $display("FAIL b2b_drive1: got %h want 2df", configure); end
    tick();
    n_cmp++; if (configure !== 11'h2DE || tx_sent_count !== 8'd2) begin n_err++; $display("FAIL b2b_gap1: got cfg=%h cnt=%0d want 2de/2", configure, tx_sent_count); end
    tick();
  endtask

`ifdef NOC_IFACE_LOOPBACK_EN
  task automatic test_loopback();
    int strobes = 0;
    do_reset();
    router_ready = 1'b1; block_all_paths = 1'b1;
    tx_valid = 1'b1; tx_dest = 2'd2; tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (configure[0] !== 1'b0) strobes++;
    end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin n_err++; $display("FAIL loop_rx: got v=%b d=%h want 1/a5", rx_valid, rx_data); end
    n_cmp++; if (strobes != 0 || configure !== 11'd0) begin n_err++; $display("FAIL loop_cfg: got strobes=%0d cfg=%h want 0/000", strobes, configure); end
    n_cmp++; if (tx_sent_count !== 8'd0) begin n_err++; $display("FAIL loop_count: got %0d want 0", tx_sent_count); end
    block_all_paths = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_send();
    test_router_stall();
    test_tx_full();
    test_rx_overflow();
    test_rx_full_pop();
    test_reset_mid_drive();
    test_back_to_back();
`ifdef NOC_IFACE_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
